// File: rtl/bht2b.sv
// rtl/bht2b.sv - branch history table of 2-bit saturating counters
// Combinational read with same-cycle update bypass; rst/flush clear every entry to weak not-taken.
module bht2b #(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    output logic             pred_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int          NUM_ENTRIES = 1 << IDX_W;
    localparam logic [1:0]  CTR_INIT    = 2'b01;

    logic [1:0] ctr_q [NUM_ENTRIES];
    logic [1:0] upd_d;
    logic       bypass;

    function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != 2'b11) nxt = ctr + 2'b01;
        end else begin
            if (ctr != 2'b00) nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

    always_comb begin
        upd_d = sat_step(ctr_q[upd_idx], upd_taken);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else if (upd_en) begin
            ctr_q[upd_idx] <= upd_d;
        end
    end

    // A clearing cycle discards the update, so it must not be forwarded either.
    always_comb begin
        bypass = upd_en && !rst && !flush && (upd_idx == rd_idx);
        rd_ctr = bypass ? upd_d : ctr_q[rd_idx];
        pred_taken = rd_ctr[1];
    end

endmodule

// File: tb/tb_bht2b.sv
// tb/tb_bht2b.sv - directed self-checking bench for bht2b
module tb_bht2b;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [3:0] rd_idx;
    logic [1:0] rd_ctr;
    logic       pred_taken;
    logic       upd_en;
    logic [3:0] upd_idx;
    logic       upd_taken;

    int tests = 0;
    int fails = 0;

    bht2b #(.IDX_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .rd_idx     (rd_idx),
        .rd_ctr     (rd_ctr),
        .pred_taken (pred_taken),
        .upd_en     (upd_en),
        .upd_idx    (upd_idx),
        .upd_taken  (upd_taken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic read_chk(input string tag, input logic [3:0] idx, input logic [1:0] exp);
        rd_idx = idx;
        #1;
        chk(tag, rd_ctr, exp);
        chk({tag, "_pred"}, {1'b0, pred_taken}, {1'b0, exp[1]});
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic upd_once(input logic [3:0] idx, input logic taken);
        upd_en = 1'b1;
        upd_idx = idx;
        upd_taken = taken;
        edge_step();
        upd_en = 1'b0;
    endtask

    logic [1:0] up_exp [4];
    logic [1:0] dn_exp [4];

    initial begin
        up_exp[0] = 2'b10; up_exp[1] = 2'b11; up_exp[2] = 2'b11; up_exp[3] = 2'b11;
        dn_exp[0] = 2'b10; dn_exp[1] = 2'b01; dn_exp[2] = 2'b00; dn_exp[3] = 2'b00;

        rst = 1'b1; flush = 1'b0; rd_idx = '0;
        upd_en = 1'b0; upd_idx = '0; upd_taken = 1'b0;
        edge_step();
        rst = 1'b0;

        for (int i = 0; i < 16; i++) read_chk($sformatf("reset_idx%0d", i), 4'(i), 2'b01);

        for (int k = 0; k < 4; k++) begin
            upd_once(4'd3, 1'b1);
            read_chk($sformatf("sat_up_%0d", k), 4'd3, up_exp[k]);
        end
        read_chk("sat_up_idx2", 4'd2, 2'b01);
        read_chk("sat_up_idx4", 4'd4, 2'b01);

        for (int k = 0; k < 4; k++) begin
            upd_once(4'd3, 1'b0);
            read_chk($sformatf("sat_dn_%0d", k), 4'd3, dn_exp[k]);
        end

        rd_idx = 4'd5; upd_en = 1'b1; upd_idx = 4'd5; upd_taken = 1'b1;
        #1;
        chk("bypass_hit", rd_ctr, 2'b10);
        chk("bypass_hit_pred", {1'b0, pred_taken}, 2'b01);
        upd_idx = 4'd6;
        #1;
        chk("bypass_miss", rd_ctr, 2'b01);
        upd_en = 1'b0;
        edge_step();
        read_chk("bypass_nowrite", 4'd5, 2'b01);

        upd_en = 1'b1; upd_idx = 4'd10; upd_taken = 1'b1;
        edge_step();
        edge_step();
        upd_en = 1'b0;
        read_chk("b2b_taken", 4'd10, 2'b11);

        upd_once(4'd1, 1'b1);
        upd_once(4'd1, 1'b1);
        upd_once(4'd7, 1'b0);
        read_chk("pre_flush_idx1", 4'd1, 2'b11);
        read_chk("pre_flush_idx7", 4'd7, 2'b00);
        flush = 1'b1; upd_en = 1'b1; upd_idx = 4'd1; upd_taken = 1'b0; rd_idx = 4'd1;
        #1;
        chk("flush_no_bypass", rd_ctr, 2'b11);
        edge_step();
        flush = 1'b0; upd_en = 1'b0;
        read_chk("flush_idx1", 4'd1, 2'b01);
        read_chk("flush_idx7", 4'd7, 2'b01);
        read_chk("flush_idx10", 4'd10, 2'b01);

        upd_once(4'd9, 1'b1);
        read_chk("pre_rst_idx9", 4'd9, 2'b10);
        rst = 1'b1; upd_en = 1'b1; upd_idx = 4'd9; upd_taken = 1'b1; rd_idx = 4'd9;
        #1;
        chk("rst_no_bypass", rd_ctr, 2'b10);
        edge_step();
        rst = 1'b0; upd_en = 1'b0;
        read_chk("rst_mid_idx9", 4'd9, 2'b01);
        upd_once(4'd9, 1'b1);
        read_chk("post_rst_upd", 4'd9, 2'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
